ebus_xfer_ctl: RTL and testbench

- Sequences one EBUS I/O transfer at a time between the EBOX and an EBUS device (DTE20, RH20).
- Covers CONO/DATAO (EBOX drives data) and CONI/DATAI (device drives data).
- Sits beside the top-level EBUS mux:
  - drives one tEBUSdriver slot (driving, data) for output cycles;
  - consumes the muxed EBUS data for input cycles.
- Generates controller select, function and demand; waits for the device transfer handshake, with a timeout.

---
 rtl/ebus_xfer_ctl.sv | 176 +++++++++++++++++
 tb/tb_ebus_xfer_ctl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ebus_xfer_ctl.sv
// EBUS transfer sequencer: one CONO/DATAO or CONI/DATAI cycle at a time.
// Drives cs/func, raises demand after setup, waits on the device xfer handshake with a timeout.
//
//   state   | meaning
//   IDLE    | no transfer; accept req
//   SETUP   | cs/func stable, counting setup; waits out a stale xfer
//   DEMAND  | demand high, waiting for xfer to rise
//   RELEASE | demand dropped, waiting for xfer to fall
module ebus_xfer_ctl #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        eboxClk,
  input  logic        eboxReset,
  input  logic        req,
  input  logic        isInput,
  input  logic [2:0]  func,
  input  logic [6:0]  cs,
  input  logic [35:0] wrData,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [35:0] rdData,
  output logic [6:0]  ebusCS,
  output logic [2:0]  ebusFunc,
  output logic        ebusDemand,
  input  logic        ebusXfer,
  input  logic [35:0] ebusDataIn,
  output logic        ebusDriving,
  output logic [35:0] ebusDataOut
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_DEMAND  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Down-counter terminal count is zero, so loads are N-1.
  localparam logic [9:0] SETUP_LOAD = 10'(SETUP_CYCLES - 1);
  localparam logic [9:0] TO_LOAD    = 10'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state;
  logic [9:0]  r_cnt, w_cnt;
  logic        r_is_in, w_is_in;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_timeout, w_timeout;
  logic [35:0] r_rd, w_rd;
  logic [6:0]  r_cs, w_cs;
  logic [2:0]  r_func, w_func;
  logic        r_demand, w_demand;
  logic        r_driving, w_driving;
  logic [35:0] r_dout, w_dout;

  always_ff @(posedge eboxClk or negedge eboxReset) begin
    if (!eboxReset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_is_in   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_rd      <= '0;
      r_cs      <= '0;
      r_func    <= '0;
      r_demand  <= 1'b0;
      r_driving <= 1'b0;
      r_dout    <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_is_in   <= w_is_in;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_timeout <= w_timeout;
      r_rd      <= w_rd;
      r_cs      <= w_cs;
      r_func    <= w_func;
      r_demand  <= w_demand;
      r_driving <= w_driving;
      r_dout    <= w_dout;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_is_in   = r_is_in;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    w_rd      = r_rd;
    w_cs      = r_cs;
    w_func    = r_func;
    w_demand  = r_demand;
    w_driving = r_driving;
    w_dout    = r_dout;

    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_state   = ST_SETUP;
          w_cnt     = SETUP_LOAD;
          w_is_in   = isInput;
          w_busy    = 1'b1;
          w_cs      = cs;
          w_func    = func;
          w_driving = ~isInput;
          w_dout    = isInput ? 36'd0 : wrData;
        end
      end

      ST_SETUP: begin
        if (r_cnt != 10'd0) begin
          w_cnt = r_cnt - 10'd1;
        end else if (!ebusXfer) begin
          w_state  = ST_DEMAND;
          w_demand = 1'b1;
          w_cnt    = TO_LOAD;
        end
      end

      ST_DEMAND: begin
        if (ebusXfer) begin
          if (r_is_in) w_rd = ebusDataIn;
          w_state  = ST_RELEASE;
          w_demand = 1'b0;
          w_cnt    = TO_LOAD;
        end else if (r_cnt == 10'd0) begin
          w_state   = ST_IDLE;
          w_timeout = 1'b1;
          w_busy    = 1'b0;
          w_demand  = 1'b0;
          w_cs      = '0;
          w_func    = '0;
          w_driving = 1'b0;
          w_dout    = '0;
        end else begin
          w_cnt = r_cnt - 10'd1;
        end
      end

      ST_RELEASE: begin
        if (!ebusXfer || r_cnt == 10'd0) begin
          // Falling xfer completes the cycle; a stuck-high xfer aborts it.
          w_state   = ST_IDLE;
          w_done    = ~ebusXfer;
          w_timeout = ebusXfer;
          w_busy    = 1'b0;
          w_demand  = 1'b0;
          w_cs      = '0;
          w_func    = '0;
          w_driving = 1'b0;
          w_dout    = '0;
        end else begin
          w_cnt = r_cnt - 10'd1;
        end
      end

      default: w_state = ST_IDLE;
    endcase
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign rdData      = r_rd;
  assign ebusCS      = r_cs;
  assign ebusFunc    = r_func;
  assign ebusDemand  = r_demand;
  assign ebusDriving = r_driving;
  assign ebusDataOut = r_dout;

endmodule

// File: tb/tb_ebus_xfer_ctl.sv
// Bench for ebus_xfer_ctl: directed vector table, reset corner case and random transfers,
// each checked cycle by cycle against a timeline computed from the handshake schedule.
module tb_ebus_xfer_ctl;
  localparam int S = 2;
  localparam int T = 8;

  logic        eboxClk = 1'b0;
  logic        eboxReset = 1'b0;
  logic        req = 1'b0;
  logic        isInput = 1'b0;
  logic [2:0]  func = '0;
  logic [6:0]  cs = '0;
  logic [35:0] wrData = '0;
  logic        busy, done, timeout;
  logic [35:0] rdData;
  logic [6:0]  ebusCS;
  logic [2:0]  ebusFunc;
  logic        ebusDemand;
  logic        ebusXfer = 1'b0;
  logic [35:0] ebusDataIn = '0;
  logic        ebusDriving;
  logic [35:0] ebusDataOut;

  ebus_xfer_ctl #(.SETUP_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .eboxClk(eboxClk), .eboxReset(eboxReset), .req(req), .isInput(isInput),
    .func(func), .cs(cs), .wrData(wrData), .busy(busy), .done(done),
    .timeout(timeout), .rdData(rdData), .ebusCS(ebusCS), .ebusFunc(ebusFunc),
    .ebusDemand(ebusDemand), .ebusXfer(ebusXfer), .ebusDataIn(ebusDataIn),
    .ebusDriving(ebusDriving), .ebusDataOut(ebusDataOut)
  );

  always #5 eboxClk = ~eboxClk;

  typedef struct {
    bit          inp;
    logic [6:0]  cs;
    logic [2:0]  fn;
    logic [35:0] wd;
    logic [35:0] din;
    int          st;      // edges after E0 that a stale xfer stays high (0 = none)
    int          a;       // xfer first sampled high this many edges after demand rises
    int          h;       // extra edges xfer stays high after the ack edge
    bit          hold;    // keep req high, chaining straight into the next transfer
    int          exp_len; // edges from E0 to the done/timeout pulse
    bit          exp_to;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [35:0] rd_model = '0;
  vec_t vecs[9];

  function automatic logic [35:0] r36();
    logic [63:0] x;
    x = {$urandom, $urandom};
    return x[35:0];
  endfunction

  function automatic logic [127:0] obs();
    return {41'b0, busy, done, timeout, ebusDemand, ebusDriving, ebusCS, ebusFunc, ebusDataOut, rdData};
  endfunction

  function automatic logic [127:0] mk(input logic b, d, t, dm, dr, input logic [6:0] c,
                                      input logic [2:0] f, input logic [35:0] o, r);
    return {41'b0, b, d, t, dm, dr, c, f, o, r};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req = 1'b0;
      ebusXfer = 1'($urandom);
      @(posedge eboxClk);
      @(negedge eboxClk);
      check("idle", obs(), mk(0, 0, 0, 0, 0, 7'd0, 3'd0, 36'd0, rd_model));
    end
    ebusXfer = 1'b0;
  endtask

  // Called at a negedge; the next posedge is E0. Returns at the negedge showing the pulse.
  task automatic run_xfer(input vec_t v, input string tag, output int obs_end, output bit obs_to);
    int ed, ex, endk, j;
    bit to, act, dm;
    ed = (v.st > 0 && v.st + 1 > S) ? v.st + 1 : S;
    ex = (v.a <= T) ? ed + v.a : -1;
    if (ex < 0) begin
      endk = ed + T; to = 1'b1;
    end else if (v.h < T) begin
      endk = ex + v.h + 1; to = 1'b0;
    end else begin
      endk = ex + T; to = 1'b1;
    end
    req = 1'b1; isInput = v.inp; cs = v.cs; func = v.fn; wrData = v.wd;
    ebusXfer = (v.st > 0);
    ebusDataIn = r36();
    obs_end = -1; obs_to = 1'b0;
    for (int k = 0; k <= endk; k++) begin
      @(posedge eboxClk);
      @(negedge eboxClk);
      if (v.inp && ex >= 0 && k == ex) rd_model = v.din;
      act = (k < endk);
      dm = (k >= ed) && ((ex < 0) ? (k < endk) : (k < ex));
      check($sformatf("%s_cyc%0d", tag, k), obs(),
            mk(act, k == endk && !to, k == endk && to, dm, act && !v.inp,
               act ? v.cs : 7'd0, act ? v.fn : 3'd0, (act && !v.inp) ? v.wd : 36'd0, rd_model));
      if (obs_end < 0 && (done || timeout)) begin
        obs_end = k; obs_to = timeout;
      end
      j = k + 1;
      req = v.hold;
      isInput = 1'($urandom); cs = 7'($urandom); func = 3'($urandom); wrData = r36();
      ebusXfer = (j <= endk) && ((v.st > 0 && j <= v.st) || (ex >= 0 && j >= ex && j <= ex + v.h));
      ebusDataIn = (j == ex) ? v.din : r36();
    end
  endtask

  initial begin
    int oe;
    bit ot;
    vec_t v;

    vecs[0] = '{1'b0, 7'o20, 3'o2, 36'o123456_701234, 36'd0, 0, 3, 1, 1'b0, 7, 1'b0};
    vecs[1] = '{1'b1, 7'o21, 3'o3, 36'o1, 36'o777000_000777, 0, 1, 0, 1'b0, 4, 1'b0};
    vecs[2] = '{1'b1, 7'o22, 3'o1, 36'o0, 36'o555, 0, 9, 0, 1'b0, 10, 1'b1};
    vecs[3] = '{1'b0, 7'o23, 3'o4, 36'o707070_707070, 36'd0, 5, 1, 0, 1'b0, 8, 1'b0};
    vecs[4] = '{1'b1, 7'o24, 3'o5, 36'o0, 36'o111222_333444, 0, 1, 8, 1'b0, 11, 1'b1};
    vecs[5] = '{1'b0, 7'o25, 3'o6, 36'o1, 36'd0, 0, 8, 7, 1'b0, 18, 1'b0};
    vecs[6] = '{1'b1, 7'o126, 3'o7, 36'o0, 36'o246, 2, 1, 0, 1'b0, 5, 1'b0};
    vecs[7] = '{1'b0, 7'o26, 3'o7, 36'o333, 36'd0, 0, 1, 0, 1'b1, 4, 1'b0};
    vecs[8] = '{1'b1, 7'o27, 3'o0, 36'o0, 36'o444, 0, 1, 0, 1'b0, 4, 1'b0};

    #3 check("reset_state", obs(), 128'd0);
    @(negedge eboxClk);
    @(negedge eboxClk);
    eboxReset = 1'b1;
    idle(2);

    for (int i = 0; i < 9; i++) begin
      run_xfer(vecs[i], $sformatf("vec%0d", i), oe, ot);
      check($sformatf("vec%0d_len", i), 128'(oe), 128'(vecs[i].exp_len));
      check($sformatf("vec%0d_kind", i), 128'(ot), 128'(vecs[i].exp_to));
      if (!vecs[i].hold) idle(1);
    end

    // Reset while demand is up, asserted between clock edges.
    req = 1'b1; isInput = 1'b0; cs = 7'o33; func = 3'o5; wrData = r36(); ebusXfer = 1'b0;
    @(posedge eboxClk);
    @(negedge eboxClk);
    req = 1'b0;
    repeat (S - 1) @(posedge eboxClk);
    @(posedge eboxClk);
    @(negedge eboxClk);
    check("rst_demand_up", 128'(ebusDemand), 128'd1);
    #2 eboxReset = 1'b0;
    #1 check("rst_async_clear", obs(), 128'd0);
    rd_model = '0;
    ebusXfer = 1'b1;
    @(posedge eboxClk);
    @(negedge eboxClk);
    check("rst_held", obs(), 128'd0);
    eboxReset = 1'b1;
    ebusXfer = 1'b0;
    idle(3);
    v = '{1'b1, 7'o34, 3'o6, 36'o0, 36'o135_246_357, 0, 2, 1, 1'b0, 6, 1'b0};
    run_xfer(v, "post_rst", oe, ot);
    check("post_rst_len", 128'(oe), 128'(v.exp_len));
    check("post_rst_kind", 128'(ot), 128'(v.exp_to));
    idle(1);

    for (int i = 0; i < 40; i++) begin
      v.inp = 1'($urandom);
      v.cs = 7'($urandom);
      v.fn = 3'($urandom);
      v.wd = r36();
      v.din = r36();
      v.st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      v.a = int'($urandom_range(1, 10));
      v.h = int'($urandom_range(0, 9));
      v.hold = (i < 39) && ($urandom_range(0, 2) == 0);
      v.exp_len = 0;
      v.exp_to = 1'b0;
      run_xfer(v, $sformatf("rnd%0d", i), oe, ot);
      if (!v.hold) idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
